rv32i_hazard_ctrl: RTL and testbench
====================================

// Module: rv32i_hazard_ctrl
// PURPOSE
//  Pipeline interlock/flush scheduler for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
//  Tracks in-flight destination registers in a 3-slot scoreboard (EX, MEM, WB).
//  Stalls IF/ID and injects EX bubbles on RAW hazards; there is no forwarding.
//  Kills wrong-path instructions after a taken branch/jump is resolved in EX.
// PARAMETERS
//  REG_W        5   register index width
//  FLUSH_CYCLES 2   kill cycles after a taken branch (covers sync-RAM fetch latency); >=1
//  STALL_LIMIT  15  consecutive-stall watchdog threshold
//  PERF_W       8   stall performance counter width
// PORTS
//  clk              in   1      clock
//  reset            in   1      asynchronous, active-low reset
//  id_valid         in   1      ID stage holds a valid instruction
//  id_rs1, id_rs2   in   REG_W  source register indices
//  id_rs1_used      in   1      instruction reads rs1
//  id_rs2_used      in   1      instruction reads rs2
//  id_rd            in   REG_W  destination register index
//  id_wb_en         in   1      instruction writes rd
//  ex_branch_taken  in   1      EX resolved a taken branch or jump this cycle
//  perf_clr         in   1      synchronous clear of stall_count
//  stall_if         out  1      hold the PC
//  stall_id         out  1      hold the IF/ID register
//  bubble_ex        out  1      load a NOP into ID/EX
//  flush_id         out  1      invalidate the IF/ID register
//  state_out        out  2      registered FSM state: RUN=0, STALL=1, FLUSH=2
//  stall_count      out  PERF_W saturating count of stall cycles
//  stall_timeout    out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset (reset==0):
//   - All scoreboard slots invalid; state RUN; counters 0; stall_timeout 0.
//   - All outputs are forced to 0 combinationally while reset is low.
//  Matching:
//   - Slot = {v, rd}. match(r) = r!=0 && any valid slot has rd==r.
//   - x0 never hazards.
//  Hazard and issue:
//   - hazard = id_valid && ((id_rs1_used && match(id_rs1)) || (id_rs2_used && match(id_rs2))).
//   - flushing = ex_branch_taken || state==FLUSH.
//   - issue = id_valid && !hazard && !flushing.
//  Scoreboard update, every edge:
//   - s_wb <= s_mem; s_mem <= s_ex.
//   - s_ex <= issue ? {id_wb_en && id_rd!=0, id_rd} : invalid.
//  Stall outputs (combinational, same cycle):
//   - If hazard && !flushing: stall_if = stall_id = bubble_ex = 1.
//   - Otherwise stall_if = stall_id = 0.
//   - Latency: a dependent instruction directly after its producer stalls exactly 3 cycles and issues in cycle 4.
//  Flush:
//   - If flushing: flush_id = bubble_ex = 1 and stall_if = stall_id = 0 (flush beats stall).
//  FSM transitions:
//   - RUN/STALL -> FLUSH on ex_branch_taken; flush counter loads FLUSH_CYCLES-1.
//   - FLUSH: counter decrements each cycle; at 0 and no new ex_branch_taken, go to RUN or STALL per hazard.
//   - ex_branch_taken while in FLUSH reloads the counter.
//   - RUN <-> STALL follows hazard && !flushing, registered at each edge.
//  Counters:
//   - stall_count increments on each hazard && !flushing cycle and saturates at all-ones.
//   - perf_clr has priority over increment.
//   - The run counter counts consecutive stall cycles and clears on any non-stall cycle.
//   - The run counter exceeding STALL_LIMIT sets stall_timeout, which clears only on reset.
//   - Legal operation never exceeds 3 consecutive stalls.
//  Reset mid-operation: scoreboard contents are discarded; no stall is produced after release.
// STRUCTURE
//  rv32i_pkg holds:
//   - hz_state_e (RUN, STALL, FLUSH)
//   - sb_slot_t {logic v; logic [4:0] rd;}
//   - REG_X0 constant
//  Sub-module rv32i_sb_pipe: the 3-slot shift register plus the two match comparators.
//  FSM and counters live in the top.
// TESTING
//  1. Reset low with random inputs -> all outputs 0; after release state_out=0, stall_count=0.
//  2. Issue rd=5 with wb_en, next ID rs1=5 used -> stall_if/stall_id/bubble_ex=1 for 3 cycles,
//     issue in cycle 4, stall_count=3.
//  3. rd=0 with wb_en, then rs1=0 used; also rd=7 with wb_en=0, then rs2=7 used -> never stalls.
//  4. ex_branch_taken for 1 cycle while a hazard is pending -> flush_id=bubble_ex=1 for 2 cycles,
//     stall_if=0, state FLUSH then RUN, stall_count unchanged.
//  5. Assert reset in the 2nd stall cycle -> outputs 0 immediately; after release, ID rs1=5 issues
//     without stall.
//  6. 100 dependent pairs -> stall_count saturates at 255; perf_clr together with a stall
//     -> stall_count=0; stall_timeout stays 0 throughout.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I hazard controller: FSM states,
// scoreboard slot layout, x0 constant and the slot-hit helper.
package rv32i_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_slot_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic sb_hit(
    sb_slot_t   s,
    logic [4:0] r
  );
    return s.v && (r != REG_X0)
      && (s.rd == r);
  endfunction

endpackage

// File: rtl/rv32i_hazard_ctrl_if.sv
// ID/EX side of the hazard controller: decoded operand info in,
// stall/bubble/flush controls out. master = pipeline, slave = ctrl.
interface rv32i_hazard_ctrl_if #(
  parameter int REG_W = 5
) ();

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_wb_en;
  logic             ex_branch_taken;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_id;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_wb_en,
    output ex_branch_taken,
    input  stall_if, stall_id,
    input  bubble_ex, flush_id
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_wb_en,
    input  ex_branch_taken,
    output stall_if, stall_id,
    output bubble_ex, flush_id
  );

endinterface

// File: rtl/rv32i_sb_pipe.sv
// 3-slot destination scoreboard (EX, MEM, WB) shifting every edge.
// Ports: issue/wb_en/rd load EX slot; rs1/rs2 -> match1/match2.
module rv32i_sb_pipe
  import rv32i_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             wb_en,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             match1,
  output logic             match2
);

  sb_slot_t ex_q, ex_d;
  sb_slot_t mem_q;
  sb_slot_t wb_q;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.v  = wb_en && (rd != REG_X0);
      ex_d.rd = rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // No forwarding: any in-flight producer blocks the reader.
  assign match1 = sb_hit(ex_q, rs1)
    || sb_hit(mem_q, rs1)
    || sb_hit(wb_q, rs1);
  assign match2 = sb_hit(ex_q, rs2)
    || sb_hit(mem_q, rs2)
    || sb_hit(wb_q, rs2);

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Interlock/flush scheduler: RAW stalls, branch kills, perf + watchdog.
// Ports: clk, reset (async low), hz (slave), perf_clr, state/count/timeout.
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_LIMIT  = 15,
  parameter int PERF_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  rv32i_hazard_ctrl_if.slave hz,
  input  logic              perf_clr,
  output logic [1:0]        state_out,
  output logic [PERF_W-1:0] stall_count,
  output logic              stall_timeout
);

  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
  localparam int RUN_W = $clog2(STALL_LIMIT + 2);

  hz_state_e         state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [PERF_W-1:0] scnt_q, scnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              tmo_q, tmo_d;

  logic m1, m2;
  logic hazard, flushing, stall, issue;

  rv32i_sb_pipe #(
    .REG_W (REG_W)
  ) u_sb (
    .clk    (clk),
    .reset  (reset),
    .issue  (issue),
    .wb_en  (hz.id_wb_en),
    .rd     (hz.id_rd),
    .rs1    (hz.id_rs1),
    .rs2    (hz.id_rs2),
    .match1 (m1),
    .match2 (m2)
  );

  always_comb begin
    hazard = hz.id_valid
      && ((hz.id_rs1_used && m1)
       || (hz.id_rs2_used && m2));
    flushing = hz.ex_branch_taken
      || (state_q == FLUSH);
    stall = hazard && !flushing;
    issue = hz.id_valid
      && !hazard && !flushing;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (hz.ex_branch_taken) begin
      state_d = FLUSH;
      fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      // Leave as the counter reaches zero.
      if (fcnt_q <= FC_W'(1)) begin
        fcnt_d  = '0;
        state_d = hazard ? STALL : RUN;
      end else begin
        fcnt_d = fcnt_q - FC_W'(1);
      end
    end else begin
      state_d = stall ? STALL : RUN;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (perf_clr) begin
      scnt_d = '0;
    end else if (stall && (scnt_q != '1)) begin
      scnt_d = scnt_q + PERF_W'(1);
    end
    run_d = '0;
    if (stall) begin
      run_d = (run_q == '1) ? run_q
        : run_q + RUN_W'(1);
    end
    tmo_d = tmo_q
      || (run_q > RUN_W'(STALL_LIMIT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      scnt_q  <= '0;
      run_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
    end
  end

  assign hz.stall_if  = reset && stall;
  assign hz.stall_id  = reset && stall;
  assign hz.bubble_ex = reset
    && (stall || flushing);
  assign hz.flush_id  = reset && flushing;

  assign state_out     = reset ? 2'(state_q) : 2'b0;
  assign stall_count   = reset ? scnt_q : '0;
  assign stall_timeout = reset && tmo_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Self-checking bench: per-cycle reference model plus directed
// literal checks for rv32i_hazard_ctrl.
module tb_rv32i_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       perf_clr = 1'b0;
  logic [1:0] state_out;
  logic [7:0] stall_count;
  logic       stall_timeout;

  int tests = 0;
  int fails = 0;

  rv32i_hazard_ctrl_if #(.REG_W(5)) hz ();

  rv32i_hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .hz            (hz),
    .perf_clr      (perf_clr),
    .state_out     (state_out),
    .stall_count   (stall_count),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
        nm, act, exp, $time);
    end
  endtask

  // Reference model: register busy windows by cycle number.
  int  cyc = 0;
  int  busy_until[32];
  int  flush_end = -1;
  int  sc_m = 0;
  int  run_m = 0;
  bit  tmo_m = 0;
  int  st_m = 0;

  function automatic bit busy(logic [4:0] r);
    return (r != 0) && (busy_until[r] >= cyc);
  endfunction

  always @(negedge clk) begin
    bit haz, fl, stl;
    if (!reset) begin
      check("rst_stall_if", hz.stall_if, 0);
      check("rst_stall_id", hz.stall_id, 0);
      check("rst_bubble", hz.bubble_ex, 0);
      check("rst_flush", hz.flush_id, 0);
      check("rst_state", state_out, 0);
      check("rst_count", stall_count, 0);
      check("rst_tmo", stall_timeout, 0);
      for (int i = 0; i < 32; i++) busy_until[i] = -1;
      flush_end = -1;
      sc_m = 0;
      run_m = 0;
      tmo_m = 0;
      st_m = 0;
    end else begin
      haz = hz.id_valid
        && ((hz.id_rs1_used && busy(hz.id_rs1))
         || (hz.id_rs2_used && busy(hz.id_rs2)));
      fl = hz.ex_branch_taken || (cyc <= flush_end);
      stl = haz && !fl;
      check("m_stall_if", hz.stall_if, int'(stl));
      check("m_stall_id", hz.stall_id, int'(stl));
      check("m_bubble", hz.bubble_ex, int'(stl || fl));
      check("m_flush", hz.flush_id, int'(fl));
      check("m_state", state_out, st_m);
      check("m_count", stall_count, sc_m);
      check("m_tmo", stall_timeout, int'(tmo_m));
      if (hz.id_valid && !haz && !fl
          && hz.id_wb_en && hz.id_rd != 0)
        busy_until[hz.id_rd] = cyc + 3;
      if (hz.ex_branch_taken)
        flush_end = cyc + FLUSH_CYCLES - 1;
      st_m = (cyc + 1 <= flush_end) ? 2 : (haz ? 1 : 0);
      if (perf_clr) sc_m = 0;
      else if (stl && sc_m < 255) sc_m++;
      if (run_m > 15) tmo_m = 1;
      run_m = stl ? run_m + 1 : 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(
    input bit v,
    input int rs1, input bit u1,
    input int rs2, input bit u2,
    input int rd, input bit wb
  );
    hz.id_valid    = v;
    hz.id_rs1      = 5'(rs1);
    hz.id_rs1_used = u1;
    hz.id_rs2      = 5'(rs2);
    hz.id_rs2_used = u2;
    hz.id_rd       = 5'(rd);
    hz.id_wb_en    = wb;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    hz.ex_branch_taken = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    // 1: reset with random inputs
    repeat (5) begin
      tick();
      set_id(1'($urandom), $urandom_range(31), 1'($urandom),
        $urandom_range(31), 1'($urandom),
        $urandom_range(31), 1'($urandom));
      hz.ex_branch_taken = 1'($urandom);
      perf_clr = 1'($urandom);
    end
    tick();
    idle();
    perf_clr = 0;
    reset = 1;
    @(negedge clk);
    check("t1_state", state_out, 0);
    check("t1_count", stall_count, 0);

    // 2: rd=5 producer then rs1=5 reader
    tick();
    set_id(1, 0, 0, 0, 0, 5, 1);
    @(negedge clk);
    check("t2_prod_stall", hz.stall_if, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_if", hz.stall_if, 1);
      check("t2_stall_id", hz.stall_id, 1);
      check("t2_bubble", hz.bubble_ex, 1);
      tick();
    end
    @(negedge clk);
    check("t2_issue", hz.stall_if, 0);
    check("t2_count", stall_count, 3);
    tick();
    idle();
    repeat (3) tick();

    // 3: x0 and non-writing producers never hazard
    set_id(1, 0, 0, 0, 0, 0, 1);
    tick();
    set_id(1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("t3_x0", hz.stall_if, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 7, 0);
    tick();
    set_id(1, 0, 0, 7, 1, 0, 0);
    @(negedge clk);
    check("t3_nowb", hz.stall_if, 0);
    tick();
    idle();
    repeat (3) tick();

    // 4: branch while a hazard is pending
    set_id(1, 0, 0, 0, 0, 5, 1);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1);
    @(negedge clk);
    check("t4_pre_stall", hz.stall_if, 1);
    tick();
    hz.ex_branch_taken = 1;
    @(negedge clk);
    check("t4_flush0", hz.flush_id, 1);
    check("t4_bubble0", hz.bubble_ex, 1);
    check("t4_stallif0", hz.stall_if, 0);
    check("t4_state0", state_out, 1);
    check("t4_count0", stall_count, 4);
    tick();
    idle();
    @(negedge clk);
    check("t4_flush1", hz.flush_id, 1);
    check("t4_bubble1", hz.bubble_ex, 1);
    check("t4_state1", state_out, 2);
    tick();
    @(negedge clk);
    check("t4_flush2", hz.flush_id, 0);
    check("t4_state2", state_out, 0);
    check("t4_count2", stall_count, 4);
    repeat (3) tick();

    // 5: reset during the 2nd stall cycle
    set_id(1, 0, 0, 0, 0, 5, 1);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1);
    @(negedge clk);
    check("t5_stall1", hz.stall_if, 1);
    tick();
    reset = 0;
    @(negedge clk);
    check("t5_rst_stall", hz.stall_if, 0);
    check("t5_rst_bubble", hz.bubble_ex, 0);
    tick();
    tick();
    reset = 1;
    @(negedge clk);
    check("t5_after", hz.stall_if, 0);
    check("t5_count", stall_count, 0);
    tick();
    idle();
    repeat (3) tick();

    // 6: saturation and clear priority
    for (int i = 0; i < 100; i++) begin
      set_id(1, 0, 0, 0, 0, (i % 31) + 1, 1);
      tick();
      set_id(1, (i % 31) + 1, 1, 0, 0, 0, 0);
      repeat (3) tick();
      tick();
    end
    @(negedge clk);
    check("t6_sat", stall_count, 255);
    check("t6_tmo", stall_timeout, 0);
    set_id(1, 0, 0, 0, 0, 9, 1);
    tick();
    set_id(1, 9, 1, 0, 0, 0, 0);
    perf_clr = 1;
    @(negedge clk);
    check("t6_clr_stall", hz.stall_if, 1);
    tick();
    perf_clr = 0;
    @(negedge clk);
    check("t6_clr", stall_count, 0);
    tick();
    idle();
    repeat (4) tick();
    @(negedge clk);
    check("t6_tmo_end", stall_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
